// File: rtl/bypass_scoreboard_if.sv
// Decode-stage operand bus between pipeline bookkeeping, register file and bypass_scoreboard.
// master drives stage/writeback/read/issue information; slave returns operands and stall.
interface bypass_scoreboard_if #(
    parameter int XLEN      = 64,
    parameter int REG_IDX_W = 5,
    parameter int NSTG      = 4,
    parameter int NRD       = 4
);
    logic                        flush;
    logic [NSTG-1:0]             stg_valid;
    logic [NSTG-1:0]             stg_wen;
    logic [NSTG*REG_IDX_W-1:0]   stg_rd;
    logic [NSTG-1:0]             stg_ready;
    logic [NSTG*XLEN-1:0]        stg_data;
    logic                        wb_valid;
    logic [REG_IDX_W-1:0]        wb_rd;
    logic [XLEN-1:0]             wb_data;
    logic [NRD*REG_IDX_W-1:0]    rd_idx;
    logic [NRD-1:0]              rd_use;
    logic [NRD*XLEN-1:0]         rf_data;
    logic                        issue_valid;
    logic                        issue_long;
    logic [REG_IDX_W-1:0]        issue_rd;
    logic [NRD*XLEN-1:0]         byp_data;
    logic [NRD-1:0]              hazard;
    logic                        stall;
    logic [(2**REG_IDX_W)-1:0]   pending;
    logic [31:0]                 stall_cnt;
    logic                        stall_timeout;

    modport master (
        output flush, stg_valid, stg_wen, stg_rd, stg_ready, stg_data,
        output wb_valid, wb_rd, wb_data, rd_idx, rd_use, rf_data,
        output issue_valid, issue_long, issue_rd,
        input  byp_data, hazard, stall, pending, stall_cnt, stall_timeout
    );

    modport slave (
        input  flush, stg_valid, stg_wen, stg_rd, stg_ready, stg_data,
        input  wb_valid, wb_rd, wb_data, rd_idx, rd_use, rf_data,
        input  issue_valid, issue_long, issue_rd,
        output byp_data, hazard, stall, pending, stall_cnt, stall_timeout
    );
endinterface

// File: rtl/bypass_scoreboard.sv
// Decode operand bypass across NSTG in-flight stages plus long-op scoreboard,
// WAW issue blocking, saturating stall counter and sticky stall watchdog.
module bypass_scoreboard #(
    parameter int XLEN      = 64,
    parameter int REG_IDX_W = 5,
    parameter int NSTG      = 4,
    parameter int NRD       = 4,
    parameter int STALL_MAX = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    bypass_scoreboard_if.slave bus
);
    localparam int NREG  = 2**REG_IDX_W;
    localparam int RUN_W = $clog2(STALL_MAX + 1);

    logic [NREG-1:0]      pending_q;
    logic [NREG-1:0]      pending_d;
    logic [31:0]          stall_cnt_q;
    logic [RUN_W-1:0]     run_q;
    logic                 timeout_q;

    logic [NRD*XLEN-1:0]  byp_data;
    logic [NRD-1:0]       hazard;
    logic                 waw;
    logic                 stall;

    logic [REG_IDX_W-1:0] src;
    logic                 hit;
    logic                 hit_ready;
    logic [XLEN-1:0]      hit_data;

    always_comb begin
        byp_data  = '0;
        hazard    = '0;
        src       = '0;
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_data  = '0;
        for (int p = 0; p < NRD; p++) begin
            src       = bus.rd_idx[p*REG_IDX_W +: REG_IDX_W];
            hit       = 1'b0;
            hit_ready = 1'b0;
            hit_data  = '0;
            // Scan oldest to youngest so the youngest match is the one left standing.
            for (int i = NSTG - 1; i >= 0; i--) begin
                if (bus.stg_valid[i] && bus.stg_wen[i] &&
                    bus.stg_rd[i*REG_IDX_W +: REG_IDX_W] == src) begin
                    hit       = 1'b1;
                    hit_ready = bus.stg_ready[i];
                    hit_data  = bus.stg_data[i*XLEN +: XLEN];
                end
            end
            if (src == '0) begin
                byp_data[p*XLEN +: XLEN] = '0;
            end else if (hit) begin
                byp_data[p*XLEN +: XLEN] = hit_data;
                hazard[p]                = bus.rd_use[p] & ~hit_ready;
            end else if (bus.wb_valid && bus.wb_rd == src) begin
                byp_data[p*XLEN +: XLEN] = bus.wb_data;
            end else begin
                byp_data[p*XLEN +: XLEN] = bus.rf_data[p*XLEN +: XLEN];
                hazard[p]                = bus.rd_use[p] & pending_q[src];
            end
        end
    end

    always_comb begin
        waw   = bus.issue_valid & bus.issue_long & (bus.issue_rd != '0) & pending_q[bus.issue_rd];
        stall = (|hazard) | waw;
    end

    // Set is applied after clear so a same-cycle issue to the writeback register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (bus.wb_valid)
            pending_d[bus.wb_rd] = 1'b0;
        if (bus.issue_valid && bus.issue_long)
            pending_d[bus.issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
        if (bus.flush)
            pending_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (stall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!stall)
                run_q <= '0;
            else if (run_q != RUN_W'(STALL_MAX))
                run_q <= run_q + RUN_W'(1);
            // Flag on the edge that brings the run count to STALL_MAX.
            if (stall && run_q == RUN_W'(STALL_MAX - 1))
                timeout_q <= 1'b1;
        end
    end

    assign bus.byp_data      = byp_data;
    assign bus.hazard        = hazard;
    assign bus.stall         = stall;
    assign bus.pending       = pending_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.stall_timeout = timeout_q;
endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_bypass_scoreboard;
    localparam int XLEN = 64;
    localparam int RW   = 5;
    localparam int NSTG = 4;
    localparam int NRD  = 4;
    localparam int SMAX = 8;

    localparam int K_BYP   = 0;
    localparam int K_HAZ   = 1;
    localparam int K_STALL = 2;
    localparam int K_PEND  = 3;
    localparam int K_CNT   = 4;
    localparam int K_TO    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bypass_scoreboard_if #(.XLEN(XLEN), .REG_IDX_W(RW), .NSTG(NSTG), .NRD(NRD)) bus ();

    bypass_scoreboard #(
        .XLEN(XLEN), .REG_IDX_W(RW), .NSTG(NSTG), .NRD(NRD), .STALL_MAX(SMAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    string       q_name[$];
    int          q_kind[$];
    int          q_port[$];
    logic [63:0] q_exp[$];
    int          checks = 0;
    int          errors = 0;
    bit          done   = 1'b0;

    task automatic expect_val(input string name, input int kind, input int port, input logic [63:0] v);
        q_name.push_back(name);
        q_kind.push_back(kind);
        q_port.push_back(port);
        q_exp.push_back(v);
    endtask

    task automatic check_now(input string name, input logic [63:0] a, input logic [63:0] e);
        checks = checks + 1;
        if (a !== e) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    function automatic logic [63:0] actual(input int kind, input int port);
        case (kind)
            K_BYP:   return bus.byp_data[port*XLEN +: XLEN];
            K_HAZ:   return 64'(bus.hazard);
            K_STALL: return 64'(bus.stall);
            K_PEND:  return 64'(bus.pending);
            K_CNT:   return 64'(bus.stall_cnt);
            default: return 64'(bus.stall_timeout);
        endcase
    endfunction

    always @(negedge clk) begin
        while (q_kind.size() > 0) begin
            string       n;
            int          k;
            int          p;
            logic [63:0] e;
            logic [63:0] a;
            n = q_name.pop_front();
            k = q_kind.pop_front();
            p = q_port.pop_front();
            e = q_exp.pop_front();
            a = actual(k, p);
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL %s: got %0h expected %0h", n, a, e);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL timeout: stimulus did not complete");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic clear_inputs();
        bus.flush       = 1'b0;
        bus.stg_valid   = '0;
        bus.stg_wen     = '0;
        bus.stg_rd      = '0;
        bus.stg_ready   = '0;
        bus.stg_data    = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.rd_idx      = '0;
        bus.rd_use      = '0;
        bus.rf_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_long  = 1'b0;
        bus.issue_rd    = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic set_stg(input int i, input logic [RW-1:0] rd, input logic [63:0] d, input logic rdy);
        bus.stg_valid[i]               = 1'b1;
        bus.stg_wen[i]                 = 1'b1;
        bus.stg_rd[i*RW +: RW]         = rd;
        bus.stg_data[i*XLEN +: XLEN]   = d;
        bus.stg_ready[i]               = rdy;
    endtask

    task automatic set_port(input int p, input logic [RW-1:0] r, input logic use_op, input logic [63:0] rf);
        bus.rd_idx[p*RW +: RW]       = r;
        bus.rd_use[p]                = use_op;
        bus.rf_data[p*XLEN +: XLEN]  = rf;
    endtask

    task automatic issue_long(input logic [RW-1:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_long  = 1'b1;
        bus.issue_rd    = rd;
    endtask

    task automatic wb(input logic [RW-1:0] rd, input logic [63:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
    endtask

    initial begin
        clear_inputs();
        // reset state; combinational path live during reset
        @(posedge clk); #1;
        check_now("rst_pending_now", 64'(bus.pending), 64'h0);
        check_now("rst_cnt_now", 64'(bus.stall_cnt), 64'h0);
        check_now("rst_timeout_now", 64'(bus.stall_timeout), 64'h0);
        set_stg(0, 5'd5, 64'h1234, 1'b1);
        set_port(0, 5'd5, 1'b1, 64'h0);
        expect_val("rst_pending", K_PEND, 0, 64'h0);
        expect_val("rst_cnt", K_CNT, 0, 64'h0);
        expect_val("rst_timeout", K_TO, 0, 64'h0);
        expect_val("rst_byp", K_BYP, 0, 64'h1234);
        next(); rst_n = 1'b1;

        // youngest stage wins; r0 reads zero
        next();
        set_stg(0, 5'd5, 64'h11, 1'b1);
        set_stg(2, 5'd5, 64'h22, 1'b1);
        set_port(0, 5'd5, 1'b1, 64'h99);
        set_port(3, 5'd0, 1'b1, 64'h55);
        expect_val("young_wins", K_BYP, 0, 64'h11);
        expect_val("r0_zero", K_BYP, 3, 64'h0);
        expect_val("young_haz", K_HAZ, 0, 64'h0);
        expect_val("young_stall", K_STALL, 0, 64'h0);

        next();
        set_stg(2, 5'd5, 64'h22, 1'b1);
        set_stg(1, 5'd6, 64'h33, 1'b0);
        set_port(0, 5'd5, 1'b1, 64'h99);
        expect_val("old_stage", K_BYP, 0, 64'h22);
        expect_val("old_haz", K_HAZ, 0, 64'h0);

        next();
        bus.stg_valid[0] = 1'b1;
        bus.stg_rd[4:0]  = 5'd5;
        bus.stg_data[63:0] = 64'hEE;
        set_port(0, 5'd5, 1'b1, 64'h99);
        expect_val("no_wen_rf", K_BYP, 0, 64'h99);

        // load in ex not ready; older ready stage must be ignored
        next();
        set_stg(0, 5'd7, 64'h77, 1'b0);
        set_stg(1, 5'd7, 64'hCC, 1'b1);
        set_port(1, 5'd7, 1'b1, 64'h0);
        set_port(2, 5'd7, 1'b0, 64'h0);
        expect_val("load_byp", K_BYP, 1, 64'h77);
        expect_val("load_nouse_byp", K_BYP, 2, 64'h77);
        expect_val("load_haz", K_HAZ, 0, 64'h2);
        expect_val("load_stall", K_STALL, 0, 64'h1);
        expect_val("load_cnt", K_CNT, 0, 64'h0);

        next();
        set_stg(1, 5'd7, 64'hAB, 1'b1);
        set_port(1, 5'd7, 1'b1, 64'h0);
        expect_val("load_adv_byp", K_BYP, 1, 64'hAB);
        expect_val("load_adv_haz", K_HAZ, 0, 64'h0);
        expect_val("load_adv_stall", K_STALL, 0, 64'h0);
        expect_val("load_adv_cnt", K_CNT, 0, 64'h1);

        // long op on r9 and same-cycle writeback bypass
        next();
        issue_long(5'd9);
        expect_val("iss9_stall", K_STALL, 0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            next();
            set_port(2, 5'd9, 1'b1, 64'h99);
            expect_val("r9_pend", K_PEND, 0, 64'h200);
            expect_val("r9_haz", K_HAZ, 0, 64'h4);
            expect_val("r9_cnt", K_CNT, 0, 64'(1 + k));
        end
        next();
        set_port(2, 5'd9, 1'b1, 64'h99);
        wb(5'd9, 64'hDEAD);
        expect_val("wb_byp", K_BYP, 2, 64'hDEAD);
        expect_val("wb_haz", K_HAZ, 0, 64'h0);
        expect_val("wb_stall", K_STALL, 0, 64'h0);
        expect_val("wb_cnt", K_CNT, 0, 64'h4);

        next();
        set_port(2, 5'd9, 1'b1, 64'h99);
        expect_val("wb_clr_pend", K_PEND, 0, 64'h0);
        expect_val("wb_clr_byp", K_BYP, 2, 64'h99);
        expect_val("wb_clr_haz", K_HAZ, 0, 64'h0);

        // WAW and set-beats-clear
        next();
        issue_long(5'd3);
        expect_val("iss3_stall", K_STALL, 0, 64'h0);
        next();
        issue_long(5'd3);
        expect_val("waw_pend", K_PEND, 0, 64'h8);
        expect_val("waw_stall", K_STALL, 0, 64'h1);
        expect_val("waw_cnt", K_CNT, 0, 64'h4);
        next();
        issue_long(5'd3);
        wb(5'd3, 64'h3);
        expect_val("waw_wb_stall", K_STALL, 0, 64'h1);
        next();
        expect_val("set_wins_pend", K_PEND, 0, 64'h8);
        expect_val("set_wins_cnt", K_CNT, 0, 64'h6);
        expect_val("set_wins_stall", K_STALL, 0, 64'h0);
        next();
        wb(5'd3, 64'h3);
        issue_long(5'd0);
        expect_val("iss_r0_stall", K_STALL, 0, 64'h0);
        next();
        expect_val("r3_clr_pend", K_PEND, 0, 64'h0);

        // flush beats everything including a same-cycle issue
        next();
        issue_long(5'd4);
        next();
        issue_long(5'd6);
        expect_val("r4_pend", K_PEND, 0, 64'h10);
        expect_val("r6_iss_stall", K_STALL, 0, 64'h0);
        next();
        bus.flush = 1'b1;
        issue_long(5'd8);
        expect_val("pre_flush_pend", K_PEND, 0, 64'h50);
        next();
        set_port(0, 5'd4, 1'b1, 64'h44);
        set_stg(0, 5'd0, 64'hFF, 1'b1);
        set_port(1, 5'd0, 1'b1, 64'h55);
        expect_val("flush_pend", K_PEND, 0, 64'h0);
        expect_val("flush_rf", K_BYP, 0, 64'h44);
        expect_val("r0_stage_zero", K_BYP, 1, 64'h0);
        expect_val("flush_haz", K_HAZ, 0, 64'h0);
        expect_val("flush_cnt", K_CNT, 0, 64'h6);

        // asynchronous reset mid-operation
        next();
        issue_long(5'd12);
        next();
        expect_val("r12_pend", K_PEND, 0, 64'h1000);
        expect_val("r12_cnt", K_CNT, 0, 64'h6);
        next();
        rst_n = 1'b0;
        expect_val("mid_rst_pend", K_PEND, 0, 64'h0);
        expect_val("mid_rst_cnt", K_CNT, 0, 64'h0);
        next(); rst_n = 1'b1;

        // watchdog: STALL_MAX consecutive stall cycles
        for (int k = 1; k <= SMAX; k++) begin
            next();
            set_stg(0, 5'd10, 64'h0, 1'b0);
            set_port(0, 5'd10, 1'b1, 64'h0);
            expect_val("wd_stall", K_STALL, 0, 64'h1);
            expect_val("wd_cnt", K_CNT, 0, 64'(k - 1));
            expect_val("wd_to_low", K_TO, 0, 64'h0);
        end
        next();
        expect_val("wd_rel_stall", K_STALL, 0, 64'h0);
        expect_val("wd_rel_cnt", K_CNT, 0, 64'h8);
        expect_val("wd_rel_to", K_TO, 0, 64'h1);
        next();
        expect_val("wd_hold_cnt", K_CNT, 0, 64'h8);
        expect_val("wd_hold_to", K_TO, 0, 64'h1);
        next();
        rst_n = 1'b0;
        set_stg(0, 5'd5, 64'h1234, 1'b1);
        set_port(0, 5'd5, 1'b1, 64'h0);
        expect_val("wd_rst_to", K_TO, 0, 64'h0);
        expect_val("wd_rst_cnt", K_CNT, 0, 64'h0);
        expect_val("wd_rst_byp", K_BYP, 0, 64'h1234);
        next(); rst_n = 1'b1;

        // broken runs must not trip the watchdog
        for (int k = 0; k < 11; k++) begin
            next();
            if (k != 5) begin
                set_stg(0, 5'd10, 64'h0, 1'b0);
                set_port(0, 5'd10, 1'b1, 64'h0);
            end
        end
        next();
        expect_val("run_reset_to", K_TO, 0, 64'h0);
        expect_val("run_reset_cnt", K_CNT, 0, 64'hA);

        next();
        next();
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bypass_scoreboard.md
# bypass_scoreboard

Parametrised operand-bypass and hazard unit for the decode stage, generalising the fixed two-slot ex/ex2/mem/wb forwarding to NSTG in-flight stages and NRD read ports. It adds a registered scoreboard of registers awaiting long-latency results (loads, mul/div), WAW issue blocking, a stall-cycle counter and a stall watchdog. It sits between the register file read and the decode/issue latch, and drives the decode stall.

## Interface
- XLEN, 64, data width
- REG_IDX_W, 5, register index width (register 0 hardwired zero)
- NSTG, 4, forwarding stages; index 0 youngest (ex), NSTG-1 oldest
- NRD, 4, read ports (e.g. rs1/rs2 of two decode slots)
- STALL_MAX, 1024, watchdog threshold in consecutive stall cycles
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- flush  in  1  pipeline flush; kills all in-flight long ops
- stg_valid  in  NSTG  stage holds a live, uncancelled instr
- stg_wen  in  NSTG  stage instr writes rd
- stg_rd  in  NSTG*REG_IDX_W  stage rd, stage i at [i*REG_IDX_W +: REG_IDX_W]
- stg_ready  in  NSTG  stage result available in stg_data
- stg_data  in  NSTG*XLEN  stage result
- wb_valid  in  1  long-op writeback this cycle
- wb_rd  in  REG_IDX_W  long-op destination
- wb_data  in  XLEN  long-op result
- rd_idx  in  NRD*REG_IDX_W  source index per port
- rd_use  in  NRD  port actually consumes its operand
- rf_data  in  NRD*XLEN  register file read data
- issue_valid  in  1  decode instr advances this cycle
- issue_long  in  1  advancing instr is long-latency
- issue_rd  in  REG_IDX_W  advancing instr rd
- byp_data  out  NRD*XLEN  bypassed operands
- hazard  out  NRD  per-port unresolved dependency
- stall  out  1  decode must hold
- pending  out  2**REG_IDX_W  scoreboard state
- stall_cnt  out  32  total stall cycles, saturating
- stall_timeout  out  1  sticky watchdog flag

## Operation
- Per port p, source r = rd_idx[p]. If r == 0: byp_data = 0, hazard = 0.
- Match in stage i: stg_valid[i] & stg_wen[i] & stg_rd[i] == r. The lowest-index (youngest) matching stage wins. byp_data = stg_data[i]; hazard = rd_use & !stg_ready[i]. Older stages are ignored even when ready.
- With no stage match and wb_valid & wb_rd == r: byp_data = wb_data, hazard = 0.
- Otherwise byp_data = rf_data[p]; hazard = rd_use & pending[r].
- WAW: with issue_valid & issue_long & pending[issue_rd] & issue_rd != 0, stall asserts.
- stall = |hazard | WAW. Upstream keeps issue_valid low while stall is high; the block does not gate it.
- Scoreboard next state, per register:
  - flush clears all bits, overriding everything.
  - Set when issue_valid & issue_long & issue_rd == r & r != 0.
  - Clear when wb_valid & wb_rd == r.
  - Set and clear on the same register in the same cycle: set wins.
  - pending[0] is always 0.
- stall_cnt increments each cycle stall = 1 and saturates at 0xFFFF_FFFF.
- Watchdog: run counter counts consecutive stall cycles and resets to 0 when stall = 0. When it reaches STALL_MAX, stall_timeout sets and stays set until reset.

## Timing
- byp_data, hazard and stall are combinational from inputs and registered pending. There is no added latency.
- pending updates on the clk edge after issue or wb. wb is bypassed in the same cycle, so a consumer of wb_rd sees no bubble.
- Reset values: pending = 0, stall_cnt = 0, run counter = 0, stall_timeout = 0. Combinational outputs follow inputs during reset.
- Reset asserted mid-operation clears all state asynchronously. Long ops still in flight are then untracked; upstream flushes them.
- flush and issue in the same cycle: flush wins; the issue's pending bit is not set.

## Test plan
- Port 0 r5; stg 0 and stg 2 both write r5 with data 0x11 / 0x22, both ready -> byp_data[0] = 0x11, hazard 0.
- Port 1 r7, rd_use 1; stg 0 writes r7 with stg_ready 0 (load in ex) -> hazard[1] = 1, stall = 1. Next cycle the stage advances to index 1 ready with data 0xAB -> byp_data = 0xAB, stall = 0.
- Issue long to r9; next cycle port 2 reads r9 -> hazard. Three cycles later wb_valid r9 with data 0xDEAD -> same cycle byp_data = 0xDEAD, hazard 0; following cycle pending[9] = 0.
- pending[3] = 1; issue_long r3 -> stall from WAW. Same-cycle wb r3 plus issue_long r3 -> pending[3] stays 1.
- Set pending r4 and r6, then flush -> pending = 0; a read of r4 returns rf_data with no hazard. Reading r0 with a stage writing r0 returns 0.
- STALL_MAX = 8; hold hazard for 8 cycles -> stall_timeout = 1 and stall_cnt = 8. Release stall -> flag stays 1 and the count holds; rst_n low -> all cleared.
